// File: rtl/cam_pkg.sv
// Shared constants for the ternary CAM and the operation encoding used to
// describe lookup/table-owner traffic.
package cam_pkg;

  localparam int unsigned DefaultWidthLog2 = 5;
  localparam int unsigned DefaultSizeLog2  = 5;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    INVAL,
    SEARCH
  } op_e;

endpackage

// File: rtl/tcam_prio_enc.sv
// Lowest-index priority encoder over the per-entry match vector, with
// any-hit and multi-hit flags. Purely combinational.
module tcam_prio_enc #(
  parameter int unsigned ARRAY_SIZE_LOG2 = 5
) (
  input  logic [2**ARRAY_SIZE_LOG2-1:0] match_i,
  output logic [ARRAY_SIZE_LOG2-1:0]    index_o,
  output logic                          any_o,
  output logic                          multi_o
);

  localparam int unsigned Depth = 2**ARRAY_SIZE_LOG2;

  always_comb begin
    index_o = '0;
    // Walk downwards so the lowest set bit is the last one assigned.
    for (int i = Depth - 1; i >= 0; i--) begin
      if (match_i[i]) begin
        index_o = ARRAY_SIZE_LOG2'(i);
      end
    end
    any_o   = |match_i;
    // Clearing the lowest set bit leaves something only if two or more were set.
    multi_o = |(match_i & (match_i - Depth'(1)));
  end

endmodule

// File: rtl/tcam.sv
// Ternary CAM: per-entry data, care mask and valid bit; registered read and
// search with lowest-index priority, plus occupancy count and full/empty flags.
module tcam
  import cam_pkg::*;
#(
  parameter int unsigned ARRAY_WIDTH_LOG2 = DefaultWidthLog2,
  parameter int unsigned ARRAY_SIZE_LOG2  = DefaultSizeLog2
) (
  input  logic                                clk,
  input  logic                                reset_i,
  input  logic                                read_i,
  input  logic [ARRAY_SIZE_LOG2-1:0]          read_index_i,
  input  logic                                write_i,
  input  logic [ARRAY_SIZE_LOG2-1:0]          write_index_i,
  input  logic [2**ARRAY_WIDTH_LOG2-1:0]      write_data_i,
  input  logic [2**ARRAY_WIDTH_LOG2-1:0]      write_mask_i,
  input  logic                                invalidate_i,
  input  logic [ARRAY_SIZE_LOG2-1:0]          invalidate_index_i,
  input  logic                                search_i,
  input  logic [2**ARRAY_WIDTH_LOG2-1:0]      search_data_i,
  output logic                                read_valid_o,
  output logic [2**ARRAY_WIDTH_LOG2-1:0]      read_value_o,
  output logic [2**ARRAY_WIDTH_LOG2-1:0]      read_mask_o,
  output logic                                search_valid_o,
  output logic [ARRAY_SIZE_LOG2-1:0]          search_index_o,
  output logic                                search_multi_o,
  output logic [ARRAY_SIZE_LOG2:0]            count_o,
  output logic                                full_o,
  output logic                                empty_o
);

  localparam int unsigned W    = 2**ARRAY_WIDTH_LOG2;
  localparam int unsigned D    = 2**ARRAY_SIZE_LOG2;
  localparam int unsigned I    = ARRAY_SIZE_LOG2;
  localparam int unsigned CntW = I + 1;

  logic [W-1:0]    data_q [D];
  logic [W-1:0]    data_d [D];
  logic [W-1:0]    mask_q [D];
  logic [W-1:0]    mask_d [D];
  logic [D-1:0]    valid_q, valid_d;
  logic [CntW-1:0] count_q, count_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;

  logic            read_valid_q, read_valid_d;
  logic [W-1:0]    read_value_q, read_value_d;
  logic [W-1:0]    read_mask_q, read_mask_d;
  logic            search_valid_q, search_valid_d;
  logic [I-1:0]    search_index_q, search_index_d;
  logic            search_multi_q, search_multi_d;

  logic [D-1:0]    match;
  logic [I-1:0]    enc_index;
  logic            enc_any;
  logic            enc_multi;
  logic            cnt_inc;
  logic            cnt_dec;
  logic            read_hit;
  logic            search_hit;

  // Matching uses pre-edge contents, giving read-before-write search semantics.
  for (genvar e = 0; e < D; e++) begin : g_match
    assign match[e] = valid_q[e] && (((data_q[e] ^ search_data_i) & mask_q[e]) == '0);
  end

  tcam_prio_enc #(
    .ARRAY_SIZE_LOG2(ARRAY_SIZE_LOG2)
  ) u_prio_enc (
    .match_i (match),
    .index_o (enc_index),
    .any_o   (enc_any),
    .multi_o (enc_multi)
  );

  always_comb begin
    data_d  = data_q;
    mask_d  = mask_q;
    valid_d = valid_q;
    if (write_i) begin
      data_d[write_index_i]  = write_data_i;
      mask_d[write_index_i]  = write_mask_i;
      valid_d[write_index_i] = 1'b1;
    end
    // Applied after the write so invalidate wins on a shared index.
    if (invalidate_i) begin
      valid_d[invalidate_index_i] = 1'b0;
    end

    cnt_inc = write_i && !valid_q[write_index_i] &&
              !(invalidate_i && (invalidate_index_i == write_index_i));
    cnt_dec = invalidate_i && valid_q[invalidate_index_i];
    count_d = count_q + CntW'(cnt_inc) - CntW'(cnt_dec);
    full_d  = (count_d == CntW'(D));
    empty_d = (count_d == '0);

    read_hit     = read_i && valid_q[read_index_i];
    read_valid_d = read_hit;
    read_value_d = read_hit ? data_q[read_index_i] : '0;
    read_mask_d  = read_hit ? mask_q[read_index_i] : '0;

    search_hit     = search_i && enc_any;
    search_valid_d = search_hit;
    search_index_d = search_hit ? enc_index : '0;
    search_multi_d = search_i && enc_multi;
  end

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      valid_q        <= '0;
      count_q        <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      read_valid_q   <= 1'b0;
      read_value_q   <= '0;
      read_mask_q    <= '0;
      search_valid_q <= 1'b0;
      search_index_q <= '0;
      search_multi_q <= 1'b0;
    end else begin
      valid_q        <= valid_d;
      count_q        <= count_d;
      full_q         <= full_d;
      empty_q        <= empty_d;
      read_valid_q   <= read_valid_d;
      read_value_q   <= read_value_d;
      read_mask_q    <= read_mask_d;
      search_valid_q <= search_valid_d;
      search_index_q <= search_index_d;
      search_multi_q <= search_multi_d;
    end
  end

  // Entry payload is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    mask_q <= mask_d;
  end

  assign read_valid_o   = read_valid_q;
  assign read_value_o   = read_value_q;
  assign read_mask_o    = read_mask_q;
  assign search_valid_o = search_valid_q;
  assign search_index_o = search_index_q;
  assign search_multi_o = search_multi_q;
  assign count_o        = count_q;
  assign full_o         = full_q;
  assign empty_o        = empty_q;

endmodule
